// File: rtl/exec_pkg.sv
// Shared constants and helpers for the execute stage (ALU opcodes, operand-B selects, transfer sizes).
// Used by processor_execution and exec_alu64.
package exec_pkg;

    localparam int DATA_W  = 64;
    localparam int INSTR_W = 32;

    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_SUB    = 3'b011;
    localparam logic [2:0] ALU_AND    = 3'b100;
    localparam logic [2:0] ALU_OR     = 3'b101;
    localparam logic [2:0] ALU_XOR    = 3'b110;

    localparam logic [1:0] SRC_REG   = 2'b00;
    localparam logic [1:0] SRC_DADDR = 2'b01;
    localparam logic [1:0] SRC_IMM   = 2'b10;
    localparam logic [1:0] SRC_ZERO  = 2'b11;

    localparam logic [3:0] XFER_DWORD = 4'd8;
    localparam logic [3:0] XFER_BYTE  = 4'd1;

    // Places a MOV imm16 into the 16-bit lane chosen by shamt, other lanes zero.
    function automatic logic [63:0] mov_place(input logic [15:0] imm16, input logic [1:0] shamt);
        logic [63:0] r;
        case (shamt)
            2'b00:   r = {48'd0, imm16};
            2'b01:   r = {32'd0, imm16, 16'd0};
            2'b10:   r = {16'd0, imm16, 32'd0};
            2'b11:   r = {imm16, 48'd0};
            default: r = 64'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/exec_alu64.sv
// Combinational 64-bit main ALU of the execute stage: result plus N/Z/V flags and an internal carry.
module exec_alu64
    import exec_pkg::*;
(
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  logic [2:0]  op_i,
    output logic [63:0] result_o,
    output logic        n_o,
    output logic        z_o,
    output logic        v_o,
    output logic        c_o
);

    logic [64:0] sum_s;
    logic [64:0] diff_s;

    // Subtraction is A + ~B + 1, so bit 64 is the no-borrow carry.
    assign sum_s  = {1'b0, a_i} + {1'b0, b_i};
    assign diff_s = {1'b0, a_i} + {1'b0, ~b_i} + 65'd1;

    // Operation select and overflow/carry generation.
    always_comb begin
        result_o = 64'd0;
        v_o      = 1'b0;
        c_o      = 1'b0;
        case (op_i)
            ALU_PASS_B: result_o = b_i;
            ALU_ADD: begin
                result_o = sum_s[63:0];
                c_o      = sum_s[64];
                v_o      = (a_i[63] == b_i[63]) && (sum_s[63] != a_i[63]);
            end
            ALU_SUB: begin
                result_o = diff_s[63:0];
                c_o      = diff_s[64];
                v_o      = (a_i[63] != b_i[63]) && (diff_s[63] != a_i[63]);
            end
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            default: result_o = 64'd0;
        endcase
    end

    assign n_o = result_o[63];
    assign z_o = (result_o == 64'd0);

endmodule

// File: rtl/processor_execution.sv
// Execute stage of the 5-stage ARM64 pipeline; every result is registered into the EX/MEM boundary.
// Optional macro EXEC_CARRY_OUT_EN adds the registered ALU carry output C.
module processor_execution
    import exec_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction_i,
    input  logic [63:0] MOVmask_o,
    input  logic [63:0] Da,
    input  logic [63:0] Db_i,
    input  logic [63:0] DT_Address,
    input  logic [63:0] ALU_Imm,
    input  logic [1:0]  ALUsrc,
    input  logic [2:0]  ALUop,
    input  logic        MemByteSize,
    input  logic        MOVcmd,
    input  logic        MOVkeep,
    output logic        Z,
    output logic        N,
    output logic        V,
    output logic [63:0] ALU_o,
    output logic [63:0] MOVkeepMux_o,
    output logic [63:0] Db_o,
    output logic [3:0]  XferSizeMux_o,
    output logic [31:0] instruction_o
`ifdef EXEC_CARRY_OUT_EN
    ,
    output logic        C
`endif
);

    logic [63:0] op_a_s;
    logic [63:0] op_b_s;
    logic [63:0] alu_res_s;
    logic        alu_n_s;
    logic        alu_z_s;
    logic        alu_v_s;
    logic        alu_c_s;
    logic [63:0] mov_shifted_s;

    logic [63:0] alu_d, alu_q;
    logic [63:0] mov_d, mov_q;
    logic [63:0] db_d, db_q;
    logic [3:0]  xfer_d, xfer_q;
    logic [31:0] instr_d, instr_q;
    logic        n_d, n_q;
    logic        z_d, z_q;
    logic        v_d, v_q;
    logic        c_d, c_q;

    // Operand A/B selection.
    always_comb begin
        if (MOVcmd) begin
            op_a_s = MOVmask_o;
        end else begin
            op_a_s = Da;
        end
        case (ALUsrc)
            SRC_REG:   op_b_s = Db_i;
            SRC_DADDR: op_b_s = DT_Address;
            SRC_IMM:   op_b_s = ALU_Imm;
            SRC_ZERO:  op_b_s = 64'd0;
            default:   op_b_s = 64'd0;
        endcase
    end

    exec_alu64 u_alu (
        .a_i      (op_a_s),
        .b_i      (op_b_s),
        .op_i     (ALUop),
        .result_o (alu_res_s),
        .n_o      (alu_n_s),
        .z_o      (alu_z_s),
        .v_o      (alu_v_s),
        .c_o      (alu_c_s)
    );

    assign mov_shifted_s = mov_place(instruction_i[20:5], instruction_i[22:21]);

    // Next-state values for the EX/MEM register; MOVK merges the shifted lane into the ALU result.
    always_comb begin
        alu_d   = alu_res_s;
        n_d     = alu_n_s;
        z_d     = alu_z_s;
        v_d     = alu_v_s;
        c_d     = alu_c_s;
        db_d    = Db_i;
        instr_d = instruction_i;
        if (MOVkeep) begin
            mov_d = mov_shifted_s + alu_res_s;
        end else begin
            mov_d = mov_shifted_s;
        end
        if (MemByteSize) begin
            xfer_d = XFER_BYTE;
        end else begin
            xfer_d = XFER_DWORD;
        end
    end

    // EX/MEM boundary register; reset drops whatever is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_q   <= 64'd0;
            mov_q   <= 64'd0;
            db_q    <= 64'd0;
            xfer_q  <= 4'd0;
            instr_q <= 32'd0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            v_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            alu_q   <= alu_d;
            mov_q   <= mov_d;
            db_q    <= db_d;
            xfer_q  <= xfer_d;
            instr_q <= instr_d;
            n_q     <= n_d;
            z_q     <= z_d;
            v_q     <= v_d;
            c_q     <= c_d;
        end
    end

    assign ALU_o         = alu_q;
    assign MOVkeepMux_o  = mov_q;
    assign Db_o          = db_q;
    assign XferSizeMux_o = xfer_q;
    assign instruction_o = instr_q;
    assign N             = n_q;
    assign Z             = z_q;
    assign V             = v_q;

`ifdef EXEC_CARRY_OUT_EN
    assign C = c_q;
`else
    logic unused_carry;
    assign unused_carry = c_q;
`endif

endmodule

// File: tb/tb_processor_execution.sv
// Self-checking bench for processor_execution: per-cycle reference model plus directed literal checks.
// Build with EXEC_CARRY_OUT_EN defined to also check the carry output C.
module tb_processor_execution;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction_i;
    logic [63:0] MOVmask_o, Da, Db_i, DT_Address, ALU_Imm;
    logic [1:0]  ALUsrc;
    logic [2:0]  ALUop;
    logic        MemByteSize, MOVcmd, MOVkeep;
    logic        Z, N, V;
    logic [63:0] ALU_o, MOVkeepMux_o, Db_o;
    logic [3:0]  XferSizeMux_o;
    logic [31:0] instruction_o;
`ifdef EXEC_CARRY_OUT_EN
    logic        C;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    processor_execution dut (
        .clk(clk), .reset(reset), .instruction_i(instruction_i), .MOVmask_o(MOVmask_o),
        .Da(Da), .Db_i(Db_i), .DT_Address(DT_Address), .ALU_Imm(ALU_Imm),
        .ALUsrc(ALUsrc), .ALUop(ALUop), .MemByteSize(MemByteSize), .MOVcmd(MOVcmd),
        .MOVkeep(MOVkeep), .Z(Z), .N(N), .V(V), .ALU_o(ALU_o), .MOVkeepMux_o(MOVkeepMux_o),
        .Db_o(Db_o), .XferSizeMux_o(XferSizeMux_o), .instruction_o(instruction_o)
`ifdef EXEC_CARRY_OUT_EN
        , .C(C)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference model: results straight from the arithmetic definitions of each operation.
    logic [63:0] e_alu, e_mov, e_db;
    logic [31:0] e_instr;
    logic [3:0]  e_xfer;
    logic        e_n, e_z, e_v, e_c;

    task automatic model();
        logic [63:0] a, b, r;
        logic [63:0] srcs [4];
        logic signed [65:0] wide;
        logic [64:0] usum;
        int sh;
        a = MOVcmd ? MOVmask_o : Da;
        srcs[0] = Db_i; srcs[1] = DT_Address; srcs[2] = ALU_Imm; srcs[3] = 64'd0;
        b = srcs[ALUsrc];
        r = 64'd0; e_v = 1'b0; e_c = 1'b0;
        if (ALUop == 3'd0) r = b;
        else if (ALUop == 3'd2) begin
            r = a + b;
            wide = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
            e_v = (wide != $signed({{2{r[63]}}, r}));
            usum = {1'b0, a} + {1'b0, b};
            e_c = usum[64];
        end else if (ALUop == 3'd3) begin
            r = a - b;
            wide = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
            e_v = (wide != $signed({{2{r[63]}}, r}));
            e_c = (a >= b);
        end else if (ALUop == 3'd4) r = a & b;
        else if (ALUop == 3'd5) r = a | b;
        else if (ALUop == 3'd6) r = a ^ b;
        e_alu = r;
        e_n = r[63];
        e_z = (r == 64'd0);
        sh = 16 * int'(instruction_i[22:21]);
        e_mov = {48'd0, instruction_i[20:5]} << sh;
        if (MOVkeep) e_mov = e_mov + r;
        e_xfer = MemByteSize ? 4'd1 : 4'd8;
        e_db = Db_i;
        e_instr = instruction_i;
    endtask

    // Per-cycle compare against the model, sampled 1 time unit after the active edge.
    always @(posedge clk) begin
        if (reset) begin
            e_alu = 64'd0; e_mov = 64'd0; e_db = 64'd0; e_instr = 32'd0; e_xfer = 4'd0;
            e_n = 1'b0; e_z = 1'b0; e_v = 1'b0; e_c = 1'b0;
        end else begin
            model();
        end
        #1;
        chk("m_alu", ALU_o, e_alu);
        chk("m_mov", MOVkeepMux_o, e_mov);
        chk("m_db", Db_o, e_db);
        chk("m_instr", {32'd0, instruction_o}, {32'd0, e_instr});
        chk("m_xfer", {60'd0, XferSizeMux_o}, {60'd0, e_xfer});
        chk("m_flags", {61'd0, N, Z, V}, {61'd0, e_n, e_z, e_v});
`ifdef EXEC_CARRY_OUT_EN
        chk("m_carry", {63'd0, C}, {63'd0, e_c});
`endif
    end

    task automatic defaults();
        reset = 1'b0; instruction_i = 32'd0; MOVmask_o = 64'd0; Da = 64'd0; Db_i = 64'd0;
        DT_Address = 64'd0; ALU_Imm = 64'd0; ALUsrc = 2'b00; ALUop = 3'b000;
        MemByteSize = 1'b0; MOVcmd = 1'b0; MOVkeep = 1'b0;
    endtask

    // Let one edge capture the current inputs, then settle past the model compare.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] mov_instr(input logic [1:0] shamt, input logic [15:0] imm);
        return {9'd0, shamt, imm, 5'd0};
    endfunction

    initial begin
        logic [63:0] ra, rb, exp_v;
        logic [15:0] beef;
        defaults();
        reset = 1'b1;
        Db_i = 64'hFFFF_FFFF_FFFF_FFFF;
        instruction_i = 32'hFFFF_FFFF;
        MemByteSize = 1'b0;
        step();
        chk("rst_alu", ALU_o, 64'd0);
        chk("rst_mov", MOVkeepMux_o, 64'd0);
        chk("rst_db", Db_o, 64'd0);
        chk("rst_instr", {32'd0, instruction_o}, 64'd0);
        chk("rst_xfer", {60'd0, XferSizeMux_o}, 64'd0);
        chk("rst_flags", {61'd0, N, Z, V}, 64'd0);

        @(negedge clk);
        defaults();
        Db_i = 64'h0123456789ABCDEF;
        instruction_i = 32'hDEADBEEF;
        step();
        chk("pass_db", Db_o, 64'h0123456789ABCDEF);
        chk("pass_instr", {32'd0, instruction_o}, 64'h00000000DEADBEEF);

        beef = 16'hBEEF;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            defaults();
            instruction_i = mov_instr(s[1:0], beef);
            step();
            exp_v = 64'hBEEF;
            chk("movz", MOVkeepMux_o, exp_v << (16 * s));
        end

        @(negedge clk);
        defaults();
        ALUop = 3'b010; Da = 64'h1234; MOVmask_o = 64'h5678;
        step();
        chk("opa_da", ALU_o, 64'h1234);
        @(negedge clk);
        MOVcmd = 1'b1;
        step();
        chk("opa_mask", ALU_o, 64'h5678);

        @(negedge clk);
        defaults();
        Db_i = 64'hAA; DT_Address = 64'hBB; ALU_Imm = 64'hCC; Da = 64'h99;
        ALUsrc = 2'b00; step(); chk("opb_reg", ALU_o, 64'hAA);
        @(negedge clk); ALUsrc = 2'b01; step(); chk("opb_daddr", ALU_o, 64'hBB);
        @(negedge clk); ALUsrc = 2'b10; step(); chk("opb_imm", ALU_o, 64'hCC);
        @(negedge clk); ALUsrc = 2'b11; step(); chk("opb_zero", ALU_o, 64'h0);

        @(negedge clk);
        defaults();
        step();
        chk("flag_zero", {61'd0, N, Z, V}, {61'd0, 1'b0, 1'b1, 1'b0});
        @(negedge clk);
        Db_i = -64'sd15;
        step();
        chk("flag_neg", {61'd0, N, Z, V}, {61'd0, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        defaults();
        ALUop = 3'b010; Da = 64'h7FFFFFFFFFFFFFFF; Db_i = 64'd1;
        step();
        chk("flag_ovf", {61'd0, N, Z, V}, {61'd0, 1'b1, 1'b0, 1'b1});
        chk("ovf_res", ALU_o, 64'h8000000000000000);
        @(negedge clk);
        ALUop = 3'b011; Da = 64'd5; Db_i = 64'd5;
        step();
        chk("flag_sub0", {61'd0, N, Z, V}, {61'd0, 1'b0, 1'b1, 1'b0});
        @(negedge clk);
        Da = 64'h8000000000000000; Db_i = 64'd1;
        step();
        chk("sub_ovf", {61'd0, N, Z, V}, {61'd0, 1'b0, 1'b0, 1'b1});

        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            defaults();
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            Da = ra; Db_i = rb;
            ALUop = (i % 3 == 0) ? 3'b010 : ((i % 3 == 1) ? 3'b011 : 3'b100);
            step();
            if (i % 3 == 0) chk("rnd_add", ALU_o, ra + rb);
            else if (i % 3 == 1) chk("rnd_sub", ALU_o, ra - rb);
            else chk("rnd_and", ALU_o, ra & rb);
        end

        @(negedge clk);
        defaults();
        MOVkeep = 1'b1; MOVcmd = 1'b1; Db_i = 64'h1111; MOVmask_o = 64'hFFFF_0000;
        instruction_i = mov_instr(2'b01, 16'h2222);
        step();
        chk("movk", MOVkeepMux_o, 64'h22221111);

        @(negedge clk);
        defaults();
        MemByteSize = 1'b0; step(); chk("xfer_dw", {60'd0, XferSizeMux_o}, 64'd8);
        @(negedge clk); MemByteSize = 1'b1; step(); chk("xfer_b", {60'd0, XferSizeMux_o}, 64'd1);

        @(negedge clk);
        Db_i = 64'h5555; instruction_i = 32'h1234_5678; Da = 64'h7; ALUop = 3'b101;
        reset = 1'b1;
        step();
        chk("rst_mid_alu", ALU_o, 64'd0);
        chk("rst_mid_db", Db_o, 64'd0);
        chk("rst_mid_xfer", {60'd0, XferSizeMux_o}, 64'd0);

        @(negedge clk);
        defaults();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule

// File: doc/processor_execution.md
Name: processor_execution

Overview:
- Execute stage of the 5-stage pipelined ARM64 core. Sits between the decode/register-read stage and the memory stage.
- Selects the ALU operands and runs the 64-bit main ALU to produce the N/Z/V flags.
- Builds the MOVZ/MOVK result and the memory transfer size.
- Registers every result into the EX/MEM boundary, so outputs appear 1 cycle after inputs.

Parameters:
- DATA_W, 64, datapath width; only 64 is supported.
- INSTR_W, 32, instruction width.

Ports:
- clk in 1: the single clock; all flops update on the rising edge.
- reset in 1: synchronous, active-high; clears all registered outputs.
- instruction_i in 32: decoded instruction; bits [22:21] = MOV shamt, bits [20:5] = MOV imm16.
- MOVmask_o in 64: pre-masked Rd value used as ALU operand A for MOV commands.
- Da in 64: register file port 1 data.
- Db_i in 64: register file port 2 data.
- DT_Address in 64: sign-extended load/store offset.
- ALU_Imm in 64: zero-extended ALU immediate.
- ALUsrc in 2: operand B select.
- ALUop in 3: ALU operation.
- MemByteSize in 1: 0 = doubleword (LDUR/STUR), 1 = byte (LDURB/STURB).
- MOVcmd in 1: 1 = MOV instruction; selects MOVmask_o as operand A.
- MOVkeep in 1: 0 = MOVZ, 1 = MOVK.
- Z, N, V out 1: zero, negative, overflow flags.
- ALU_o out 64: ALU result.
- MOVkeepMux_o out 64: MOV result.
- Db_o out 64: registered copy of Db_i (store data).
- XferSizeMux_o out 4: memory transfer size in bytes.
- instruction_o out 32: registered copy of instruction_i.

Behaviour:
- Operand A = MOVcmd ? MOVmask_o : Da.
- Operand B by ALUsrc: 00 = Db_i, 01 = DT_Address, 10 = ALU_Imm, 11 = 64'd0.
- ALUop results:
  - 000 PASS_B: B.
  - 010 ADD: A+B, mod 2^64.
  - 011 SUB: A-B.
  - 100 AND: A&B.
  - 101 OR: A|B.
  - 110 XOR: A^B.
  - 001 and 111: result 0.
- Flags:
  - N = result[63]; Z = (result == 0); both valid for every op.
  - V = signed overflow for ADD/SUB; V = 0 for all other ops.
  - Internal carry C = carry-out for ADD, no-borrow for SUB, 0 otherwise.
- MOV shifter: shifted = zero-extended imm16 << (16*shamt). shamt 00/01/10/11 places imm16 in bits [15:0]/[31:16]/[47:32]/[63:48].
- MOV result = MOVkeep ? (shifted + ALU result), mod 2^64 : shifted.
- Transfer size = MemByteSize ? 4'd1 : 4'd8.
- Latency: all outputs come from flops loaded every cycle from the combinational values above. Latency is exactly 1 cycle; there is no stall or enable.
- Reset: on a rising clk edge with reset = 1, every output clears to 0, including XferSizeMux_o = 0 and the flags. Reset wins over new data. Asserting reset mid-stream drops the in-flight instruction.
- There are no X-propagation guarantees for undriven inputs; the bench drives all inputs.

Optional Feature:
- Macro EXEC_CARRY_OUT_EN.
- Defined: adds output port C (1 bit), the registered ALU carry per the rules above, reset to 0.
- Undefined: no C port; carry is computed internally only and left unused.

Decomposition:
- Shared package exec_pkg holds:
  - ALU op constants: ALU_PASS_B = 3'b000, ALU_ADD = 3'b010, ALU_SUB = 3'b011, ALU_AND = 3'b100, ALU_OR = 3'b101, ALU_XOR = 3'b110.
  - ALUsrc encodings: SRC_REG, SRC_DADDR, SRC_IMM.
  - Transfer sizes: XFER_DWORD = 8, XFER_BYTE = 1.
- One sub-module is natural: exec_alu64, a combinational 64-bit ALU producing result and N/Z/V/C.
- The MOV shifter, the MOV adder and the muxes stay inline.

Test Plan:
- Reset then pass-through: hold reset 1 cycle; all outputs read 0. Then drive Db_i = 64'h0123456789ABCDEF and instruction_i = 32'hDEADBEEF; one cycle later Db_o and instruction_o equal those values.
- MOVZ shifter: MOVkeep = 0, imm16 = 16'hBEEF.
  - shamt 0..3 give MOVkeepMux_o = 64'h000000000000BEEF, 64'h00000000BEEF0000, 64'h0000BEEF00000000, 64'hBEEF000000000000, each one cycle after its stimulus.
- Operand muxes, part 1: Db_i = 0, ALUsrc = 00, ALUop = ADD. MOVcmd = 0 gives ALU_o = Da; MOVcmd = 1 gives ALU_o = MOVmask_o.
- Operand muxes, part 2: ALUop = PASS_B, ALUsrc = 00/01/10/11 gives ALU_o = Db_i / DT_Address / ALU_Imm / 0.
- Flags:
  - PASS_B with Db_i = 0 gives Z = 1, N = 0, V = 0.
  - Db_i = -15 gives Z = 0, N = 1, V = 0.
  - ADD 64'h7FFFFFFFFFFFFFFF + 1 gives V = 1, N = 1.
  - SUB 5 - 5 gives Z = 1.
- Random ops and transfer size:
  - 30 random A/B with ADD/SUB/AND cycling; ALU_o equals A+B, A-B and A&B respectively.
  - MOVK: MOVkeep = 1, MOVcmd = 1, PASS_B, Db_i = 64'h1111, imm16 = 16'h2222, shamt = 1 gives MOVkeepMux_o = 64'h22221111.
  - MemByteSize 0/1 gives XferSizeMux_o = 8/1.
